tdm_demux: RTL and testbench



---
 rtl/tdm_demux.sv | 95 +++++++++
 tb/tb_tdm_demux.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux.sv
// Time-division demultiplexer: spreads a sync-tagged serial sample stream round-robin into N_CH slots.
// Define TDM_DEMUX_SYNC_CHECK_EN to police the in_sync marker while locked (sets sticky sync_err).
module tdm_demux #(
  parameter int N_CH = 4,
  parameter int W    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [W-1:0]            in_data,
  input  logic                    in_sync,
  output logic [N_CH*W-1:0]       out_data,
  output logic                    out_frame_valid,
  output logic [$clog2(N_CH)-1:0] out_sel,
  output logic                    sync_err
);

  localparam int SEL_W = $clog2(N_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  typedef enum logic {
    HUNT,
    RUN
  } state_t;

  state_t           state;
  logic [SEL_W-1:0] ch_cnt;
  logic [W-1:0]     shadow [N_CH-1];
  logic [N_CH*W-1:0] frame;
  logic             err_q;
  logic             misplaced;
  logic             missing;

  // The last channel never needs a shadow slot: it goes straight into out_data.
  always_comb begin
    frame = '0;
    for (int c = 0; c < N_CH - 1; c++) frame[c*W +: W] = shadow[c];
    frame[(N_CH-1)*W +: W] = in_data;
  end

`ifdef TDM_DEMUX_SYNC_CHECK_EN
  assign misplaced = in_sync && (ch_cnt != '0);
  assign missing   = !in_sync && (ch_cnt == '0);
`else
  assign misplaced = 1'b0;
  assign missing   = 1'b0;
`endif

  // NOTE: non-blocking assignments here so every register sees pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= HUNT;
      ch_cnt          <= '0;
      out_data        <= '0;
      out_frame_valid <= 1'b0;
      err_q           <= 1'b0;
      // NOTE: the shadow slots are cleared on reset because a reset frame must not leak stale samples.
      for (int c = 0; c < N_CH - 1; c++) shadow[c] <= '0;
    end else begin
      out_frame_valid <= 1'b0;
      if (in_valid) begin
        unique case (state)
          HUNT: begin
            if (in_sync) begin
              shadow[0] <= in_data;
              ch_cnt    <= SEL_W'(1);
              state     <= RUN;
            end
          end
          RUN: begin
            if (misplaced) begin
              err_q     <= 1'b1;
              shadow[0] <= in_data;
              ch_cnt    <= SEL_W'(1);
            end else if (missing) begin
              err_q <= 1'b1;
              state <= HUNT;
            end else if (ch_cnt == LAST_CH) begin
              out_data        <= frame;
              out_frame_valid <= 1'b1;
              ch_cnt          <= '0;
            end else begin
              shadow[ch_cnt] <= in_data;
              ch_cnt         <= ch_cnt + SEL_W'(1);
            end
          end
        endcase
      end
    end
  end

  assign out_sel  = ch_cnt;
  assign sync_err = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux: queue-based frame model checked every cycle, plus hand-computed pins.
module tb_tdm_demux;

  localparam int N_CH = 4;
  localparam int W    = 8;
`ifdef TDM_DEMUX_SYNC_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic                    clk;
  logic                    rst;
  logic                    in_valid;
  logic [W-1:0]            in_data;
  logic                    in_sync;
  logic [N_CH*W-1:0]       out_data;
  logic                    out_frame_valid;
  logic [$clog2(N_CH)-1:0] out_sel;
  logic                    sync_err;

  tdm_demux #(.N_CH(N_CH), .W(W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_sync        (in_sync),
    .out_data       (out_data),
    .out_frame_valid(out_frame_valid),
    .out_sel        (out_sel),
    .sync_err       (sync_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 1'b0;

  // Model state: collected samples of the frame in progress, and the expected outputs.
  logic [W-1:0]      m_q[$];
  bit                m_hunt = 1'b1;
  logic [N_CH*W-1:0] m_data = '0;
  bit                m_fv   = 1'b0;
  bit                m_err  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit v, input bit s, input logic [W-1:0] d, input bit r);
    m_fv = 1'b0;
    if (r) begin
      m_q.delete();
      m_hunt = 1'b1;
      m_data = '0;
      m_err  = 1'b0;
    end else if (v) begin
      if (m_hunt) begin
        if (s) begin
          m_q.delete();
          m_q.push_back(d);
          m_hunt = 1'b0;
        end
      end else if (CHECK && s && m_q.size() != 0) begin
        m_err = 1'b1;
        m_q.delete();
        m_q.push_back(d);
      end else if (CHECK && !s && m_q.size() == 0) begin
        m_err  = 1'b1;
        m_hunt = 1'b1;
      end else begin
        m_q.push_back(d);
        if (m_q.size() == N_CH) begin
          for (int i = 0; i < N_CH; i++) m_data[i*W +: W] = m_q[i];
          m_fv = 1'b1;
          m_q.delete();
        end
      end
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic beat(input bit v, input bit s, input logic [W-1:0] d, input bit r = 1'b0);
    @(negedge clk);
    #1;
    in_valid = v;
    in_sync  = s;
    in_data  = d;
    rst      = r;
    @(posedge clk);
    model_step(v, s, d, r);
    checking = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(1'b0, 1'b0, 8'h00);
  endtask

  task automatic frame4(input logic [31:0] f);
    logic [31:0] v;
    v = f;
    beat(1'b1, 1'b1, v[7:0]);
    beat(1'b1, 1'b0, v[15:8]);
    beat(1'b1, 1'b0, v[23:16]);
    beat(1'b1, 1'b0, v[31:24]);
  endtask

  // Every cycle, away from the active edge, the DUT must match the model.
  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        check("mdl_out_data", 64'(out_data), 64'(m_data));
        check("mdl_frame_valid", 64'(out_frame_valid), 64'(m_fv));
        check("mdl_out_sel", 64'(out_sel), 64'(m_q.size()));
        check("mdl_sync_err", 64'(sync_err), 64'(m_err));
      end
    end
  end

  initial begin
    in_valid = 1'b0;
    in_sync  = 1'b0;
    in_data  = '0;
    rst      = 1'b1;

    // Reset state
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    check("rst_data", 64'(out_data), 64'h0);
    check("rst_sel", 64'(out_sel), 64'h0);
    check("rst_fv", 64'(out_frame_valid), 64'h0);
    check("rst_err", 64'(sync_err), 64'h0);

    // in_sync without in_valid must not start a frame
    beat(1'b0, 1'b1, 8'h77);
    check("novalid_sync_sel", 64'(out_sel), 64'h0);

    // Gapless frame
    beat(1'b1, 1'b1, 8'h11);
    check("f1_sel1", 64'(out_sel), 64'h1);
    beat(1'b1, 1'b0, 8'h22);
    beat(1'b1, 1'b0, 8'h33);
    check("f1_fv_early", 64'(out_frame_valid), 64'h0);
    beat(1'b1, 1'b0, 8'h44);
    check("f1_fv", 64'(out_frame_valid), 64'h1);
    check("f1_data", 64'(out_data), 64'h44332211);
    check("f1_sel", 64'(out_sel), 64'h0);
    idle(1);
    check("f1_fv_drop", 64'(out_frame_valid), 64'h0);
    check("f1_hold", 64'(out_data), 64'h44332211);

    // Same frame with a 3-cycle gap after 0x22: pulse arrives 3 cycles later
    beat(1'b1, 1'b1, 8'h11);
    beat(1'b1, 1'b0, 8'h22);
    for (int i = 0; i < 3; i++) begin
      beat(1'b0, 1'b0, 8'hEE);
      check("gap_fv", 64'(out_frame_valid), 64'h0);
      check("gap_sel", 64'(out_sel), 64'h2);
    end
    beat(1'b1, 1'b0, 8'h33);
    beat(1'b1, 1'b0, 8'h44);
    check("gap_fv_end", 64'(out_frame_valid), 64'h1);
    check("gap_data", 64'(out_data), 64'h44332211);

    // Unsynced beats after reset are discarded
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    beat(1'b1, 1'b0, 8'hAA);
    beat(1'b1, 1'b0, 8'hBB);
    check("hunt_sel", 64'(out_sel), 64'h0);
    check("hunt_fv", 64'(out_frame_valid), 64'h0);
    frame4(32'h88776655);
    check("hunt_data", 64'(out_data), 64'h88776655);

    // rst mid-frame (with a simultaneous beat) clears everything
    beat(1'b1, 1'b1, 8'h99);
    beat(1'b1, 1'b0, 8'h9A);
    beat(1'b1, 1'b0, 8'h9B, 1'b1);
    check("midrst_data", 64'(out_data), 64'h0);
    check("midrst_sel", 64'(out_sel), 64'h0);
    check("midrst_fv", 64'(out_frame_valid), 64'h0);
    beat(1'b1, 1'b1, 8'h01);
    beat(1'b1, 1'b0, 8'h02);
    beat(1'b1, 1'b0, 8'h03);
    check("midrst_fv_early", 64'(out_frame_valid), 64'h0);
    beat(1'b1, 1'b0, 8'h04);
    check("midrst_frame", 64'(out_data), 64'h04030201);

    // Back-to-back frames: one pulse per N_CH beats
    frame4(32'hA4A3A2A1);
    check("b2b_a", 64'(out_data), 64'hA4A3A2A1);
    frame4(32'hB4B3B2B1);
    check("b2b_b", 64'(out_data), 64'hB4B3B2B1);

    // Misplaced sync on the 3rd beat
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    beat(1'b1, 1'b1, 8'h11);
    beat(1'b1, 1'b0, 8'h22);
    beat(1'b1, 1'b1, 8'h33);
`ifdef TDM_DEMUX_SYNC_CHECK_EN
    check("mis_err", 64'(sync_err), 64'h1);
    check("mis_sel", 64'(out_sel), 64'h1);
    beat(1'b1, 1'b0, 8'h44);
    beat(1'b1, 1'b0, 8'h55);
    beat(1'b1, 1'b0, 8'h66);
    check("mis_fv", 64'(out_frame_valid), 64'h1);
    check("mis_data", 64'(out_data), 64'h66554433);

    // Missing sync at channel 0 drops back to hunting
    beat(1'b0, 1'b0, 8'h00, 1'b1);
    frame4(32'h44332211);
    beat(1'b1, 1'b0, 8'hA0);
    check("miss_err", 64'(sync_err), 64'h1);
    check("miss_sel", 64'(out_sel), 64'h0);
    for (int i = 0; i < N_CH; i++) beat(1'b1, 1'b0, 8'hB0 + 8'(i));
    check("miss_fv", 64'(out_frame_valid), 64'h0);
    check("miss_hold", 64'(out_data), 64'h44332211);
    frame4(32'hC4C3C2C1);
    check("miss_resync", 64'(out_data), 64'hC4C3C2C1);
    check("miss_sticky", 64'(sync_err), 64'h1);
`else
    check("mis_sel", 64'(out_sel), 64'h3);
    check("mis_err", 64'(sync_err), 64'h0);
    beat(1'b1, 1'b0, 8'h44);
    check("mis_fv", 64'(out_frame_valid), 64'h1);
    check("mis_data", 64'(out_data), 64'h44332211);
    // Missing sync at channel 0 is ignored too
    beat(1'b1, 1'b0, 8'hA0);
    check("miss_sel", 64'(out_sel), 64'h1);
    check("miss_err", 64'(sync_err), 64'h0);
`endif

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
